// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM. It deserialises (ADDR_SIZE+2)-bit
// command frames from MOSI and serialises RAM read bytes onto MISO, MSB first.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(ADDR_SIZE + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-2:0]   rx_shift;
  logic                 rd_addr_done;
  logic                 tx_loaded;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic [TXC_W-1:0]     tx_cnt;
  logic                 frame_done;
  logic                 last_bit;

  assign frame_done = (bit_cnt == CNT_W'(FRAME_W));
  assign last_bit   = (bit_cnt == CNT_W'(FRAME_W - 1));

  // NOTE: every register here is sequential state, so all updates use <= to
  // give race-free, order-independent behaviour within the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are reset too, so no X can ever reach
      // MISO or rx_data regardless of what the first frame looks like.
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_loaded    <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
    end else if (SS_n) begin
      // Deselect discards any partial frame; rd_addr_done is kept.
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_loaded <= 1'b0;
      tx_cnt    <= '0;
      rx_valid  <= 1'b0;
      MISO      <= 1'b0;
    end else begin
      // NOTE: defaults first, so rx_valid is a single-cycle pulse and MISO
      // idles low unless a branch below drives a data bit.
      rx_valid <= 1'b0;
      MISO     <= 1'b0;
      case (state)
        IDLE: begin
          state <= CHK_CMD;
        end

        CHK_CMD: begin
          rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
          bit_cnt  <= CNT_W'(1);
          if (!MOSI) begin
            state <= WRITE;
          end else if (rd_addr_done) begin
            state <= READ_DATA;
          end else begin
            state <= READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done) begin
            rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
            bit_cnt  <= bit_cnt + 1'b1;
            if (last_bit) begin
              rx_data  <= {rx_shift, MOSI};
              rx_valid <= 1'b1;
              if (state == READ_ADD) begin
                rd_addr_done <= 1'b1;
              end else if (state == READ_DATA) begin
                rd_addr_done <= 1'b0;
              end
            end
          end else if (state == READ_DATA) begin
            if (!tx_loaded) begin
              if (tx_valid) begin
                tx_shift  <= tx_data;
                MISO      <= tx_data[ADDR_SIZE-1];
                tx_loaded <= 1'b1;
                tx_cnt    <= TXC_W'(ADDR_SIZE - 1);
              end
            end else if (tx_cnt != '0) begin
              // Rotate so the next bit to send always sits just below the MSB.
              MISO     <= tx_shift[ADDR_SIZE-2];
              tx_shift <= {tx_shift[ADDR_SIZE-2:0], tx_shift[ADDR_SIZE-1]};
              tx_cnt   <= tx_cnt - 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning the data/address byte width; the frame width is ADDR_SIZE+2.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock, which is also the SPI serial clock; all logic is on the rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port `SS_n`, input, 1 bit: active-low slave select.
REQ-005 SHALL have port `MOSI`, input, 1 bit: serial data in, MSB first.
REQ-006 SHALL have port `MISO`, output, 1 bit: serial data out, MSB first, registered.
REQ-007 SHALL have port `rx_data`, output, ADDR_SIZE+2 bits: the received frame, driven to the RAM `din` input.
REQ-008 SHALL have port `rx_valid`, output, 1 bit: a one-cycle pulse marking `rx_data` as valid.
REQ-009 SHALL have port `tx_data`, input, ADDR_SIZE bits: the read byte from the RAM `dout` output.
REQ-010 SHALL have port `tx_valid`, input, 1 bit: the RAM flag marking `tx_data` as valid.

Function
REQ-011 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-012 SHALL transition to IDLE on any edge where SS_n=1, from any state, discarding a partial frame: no rx_valid, rd_addr_done unchanged, MISO<=0.
REQ-013 SHALL transition IDLE->CHK_CMD on an edge where SS_n=0; no MOSI bit is sampled on that edge.
REQ-014 SHALL, in CHK_CMD, sample MOSI as frame bit 9 and go to WRITE if MOSI=0, READ_ADD if MOSI=1 and rd_addr_done=0, or READ_DATA if MOSI=1 and rd_addr_done=1.
REQ-015 SHALL, in WRITE, READ_ADD or READ_DATA, shift in frame bits 8..0 on the next 9 edges, MSB first.
REQ-016 SHALL use a 4-bit bit counter that counts received bits and saturates at 10.
REQ-017 SHALL, on the edge sampling bit 0 (the 10th edge after entering CHK_CMD), load rx_data<={shift[8:0],MOSI} and set rx_valid<=1.
REQ-018 SHALL clear rx_valid on the following edge, so that rx_valid is high for exactly one cycle per complete frame.
REQ-019 SHALL hold rx_data until the next complete frame.
REQ-020 SHALL ignore MOSI bits after the 10th bit of a frame until SS_n=1.
REQ-021 SHALL set rd_addr_done<=1 when a READ_ADD frame completes and clear it when a READ_DATA frame completes, including completion of the MISO byte or a later abort.
REQ-022 SHALL, in READ_DATA after the frame is complete, wait for tx_valid=1; on the first such edge it loads tx_shift<=tx_data, drives MISO<=tx_data[ADDR_SIZE-1] and sets tx_loaded.
REQ-023 SHALL then shift out the remaining ADDR_SIZE-1 bits, one per edge, MSB first.
REQ-024 SHALL NOT reload tx_shift while tx_loaded=1, even though the RAM holds tx_valid high.
REQ-025 SHALL drive MISO<=0 after the last bit and whenever no bit is being shifted.
REQ-026 SHALL clear tx_loaded and the bit counter on entry to IDLE.
REQ-027 SHALL, with the RAM's one-cycle read latency, give the byte timing rx_valid at edge 10, tx_valid at edge 11, MISO bit 7 at edge 12 and bit 0 at edge 19.
REQ-028 SHALL ignore tx_valid outside READ_DATA.

Reset
REQ-029 SHALL, on any edge with rst=1, set state<=IDLE, rx_data<=0, rx_valid<=0, MISO<=0, rd_addr_done<=0, tx_loaded<=0, bit counter<=0 and tx_shift<=0.
REQ-030 SHALL let reset take priority over SS_n and all other inputs, including during a frame or a MISO shift.
REQ-031 SHALL produce no rx_valid for a frame interrupted by reset.

Verification
REQ-032 SHALL cover a write-address frame: SS_n=0, MOSI 0,0,1,0,1,0,0,1,0,1 -> rx_data=10'h0A5, rx_valid high for exactly one cycle at edge 10, MISO=0 throughout.
REQ-033 SHALL cover a read-address then read-data sequence: frame 10'h23C -> rd_addr_done=1. After SS_n high/low, frame 10'h300 with the RAM model returning tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on edges 12..19, then 0, and rd_addr_done=0.
REQ-034 SHALL cover an abort: SS_n rises after 5 bits -> no rx_valid, IDLE next edge, rx_data and rd_addr_done unchanged; the next full frame is received correctly.
REQ-035 SHALL cover a held tx_valid: tx_valid held high for 12 cycles during READ_DATA -> tx_data captured once, exactly 8 MISO bits, no repeat.
REQ-036 SHALL cover reset mid-shift: rst=1 at MISO bit 4 -> all outputs 0 and IDLE next edge. Next, an MOSI=1 frame -> READ_ADD, because rd_addr_done=0.
REQ-037 SHALL cover back-to-back frames: SS_n toggles high for 1 cycle between three write frames -> three rx_valid pulses, each one cycle, with the correct rx_data.
